// File: rtl/debounce_defs.sv
// rtl/debounce_defs.sv - shared debounce constants and the clog2 constant function
//
// Contents:
//   STABLE_CYCLES_DEFAULT : default number of qualifying samples to accept a level
//   clog2()               : ceiling log2, usable in parameter defaults
package debounce_defs;

    localparam int STABLE_CYCLES_DEFAULT = 4;

    // Ceiling log2 of value; a counter of clog2(N) bits holds 0..N-1.
    function automatic int clog2(input int value);
        int remaining;
        int result;
        remaining = value - 1;
        result    = 0;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
//
// Ports:
//   Clock : destination clock, rising edge
//   Clear : synchronous active-high reset, forces both stages to 0
//   d     : asynchronous input bit
//   q     : synchronized output (second stage)
module sync_2ff (
    input  logic Clock,
    input  logic Clear,
    input  logic d,
    output logic q
);

    // First stage may go metastable; only the second stage is ever consumed.
    logic s0;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            s0 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s0 <= d;
            q  <= s0;
        end
    end

endmodule

// File: rtl/debounce_edge_detect.sv
// rtl/debounce_edge_detect.sv - debounced level with one-cycle rise/fall pulses
//
// Parameters:
//   STABLE_CYCLES : consecutive enabled mismatching samples needed to accept a level (2..65535)
//   CNT_W         : counter width, derived from STABLE_CYCLES; leave at its default
// Ports:
//   Clock  : single clock, rising edge
//   Clear  : synchronous active-high reset
//   Din    : raw asynchronous input
//   Enable : sample tick; when low a pending qualification holds
//   Dout   : debounced registered level
//   Rise   : one-cycle pulse when Dout is accepted 0->1
//   Fall   : one-cycle pulse when Dout is accepted 1->0
//   Busy   : a candidate change is being qualified (counter non-zero)
module debounce_edge_detect
    import debounce_defs::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = clog2(STABLE_CYCLES)
) (
    input  logic Clock,
    input  logic Clear,
    input  logic Din,
    input  logic Enable,
    output logic Dout,
    output logic Rise,
    output logic Fall,
    output logic Busy
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             dout_next;
    logic             rise_next;
    logic             fall_next;

    sync_2ff u_sync (
        .Clock (Clock),
        .Clear (Clear),
        .d     (Din),
        .q     (s1)
    );

    // The count is the number of consecutive enabled samples in which the
    // synchronized input disagreed with Dout. Agreement discards any partial
    // run immediately, so a short glitch never accumulates across gaps.
    always_comb begin
        count_next = count;
        dout_next  = Dout;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (s1 == Dout) begin
            count_next = '0;
        end else if (Enable) begin
            if (count == TERMINAL) begin
                // This sample completes the run: accept and restart from zero.
                count_next = '0;
                dout_next  = s1;
                rise_next  = s1;
                fall_next  = ~s1;
            end else begin
                count_next = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            count <= '0;
            Dout  <= 1'b0;
            Rise  <= 1'b0;
            Fall  <= 1'b0;
        end else begin
            count <= count_next;
            Dout  <= dout_next;
            Rise  <= rise_next;
            Fall  <= fall_next;
        end
    end

    // Derived only from the counter register, so Din has no path to Busy.
    assign Busy = (count != '0);

endmodule

// File: doc/debounce_edge_detect.md
DEBOUNCE_EDGE_DETECT -- requirements
Module: debounce_edge_detect

Purpose: upstream conditioning stage that turns a raw, asynchronous, bouncy input into a clean synchronous D level, with one-cycle edge pulses.

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4: the number of consecutive enabled mismatching samples required to accept a new level. The legal range is 2..65535.
REQ-002 The block SHALL have parameter CNT_W, default clog2(STABLE_CYCLES): the counter width. It is derived and SHALL NOT be overridden.
REQ-003 Clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 Clear  input  1  synchronous, active-high reset.
REQ-005 Din  input  1  raw asynchronous input (switch or button).
REQ-006 Enable  input  1  sample-tick qualifier; when low, the debounce counter holds.
REQ-007 Dout  output  1  debounced registered level; this is the D source for the downstream flip-flop.
REQ-008 Rise  output  1  one-cycle pulse on an accepted 0->1 change of Dout.
REQ-009 Fall  output  1  one-cycle pulse on an accepted 1->0 change of Dout.
REQ-010 Busy  output  1  high while the counter is non-zero (a candidate change is being qualified).

Function
REQ-011 Din SHALL pass through a two-flop synchronizer (s0, s1) before any other use; no logic SHALL touch Din directly.
REQ-012 When s1 == Dout, the counter SHALL clear to 0 on the next edge, regardless of Enable.
REQ-013 When s1 != Dout and Enable=1 and the counter < STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 When s1 != Dout and Enable=1 and the counter == STABLE_CYCLES-1, the block SHALL, on the same edge, set Dout <= s1, clear the counter to 0, and set Rise (if s1=1) or Fall (if s1=0) to 1.
REQ-015 When s1 != Dout and Enable=0, the counter and Dout SHALL hold.
REQ-016 Rise and Fall SHALL be registered, SHALL be high for exactly one cycle, and SHALL never be high together.
REQ-017 With Enable tied to 1, Dout SHALL change exactly STABLE_CYCLES+2 rising edges after a clean Din step that is set up before the first edge.
REQ-018 A Din pulse or glitch that produces fewer than STABLE_CYCLES consecutive enabled mismatching samples SHALL leave Dout unchanged and produce no Rise or Fall.
REQ-019 Busy SHALL equal (counter != 0), registered-derived, with no combinational path from Din.
REQ-020 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-021 While Clear=1 on an edge: s0, s1, the counter, Dout, Rise, Fall and Busy SHALL all be 0 after that edge.
REQ-022 Clear SHALL take priority over all other conditions, including a terminal count on the same edge.
REQ-023 Clear asserted mid-qualification SHALL abort it with no pulse.
REQ-024 If Din is held at 1 through reset, the block SHALL produce a normal Rise STABLE_CYCLES+2 edges after Clear deasserts.

Structure
REQ-025 The default STABLE_CYCLES value and the clog2 constant function SHALL live in the shared package or header debounce_defs. No other shared typedefs are needed.
REQ-026 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff (ports Clock, Clear, d, q), reusable for other asynchronous inputs.
REQ-027 All other logic (counter, level register, pulse registers) SHALL reside in debounce_edge_detect.

Verification
REQ-028 The bench SHALL cover a clean rise: STABLE_CYCLES=4, Enable=1, Din 0->1 and held. Required response: Dout=1 and Rise=1 for one cycle, 6 edges later; Fall stays 0.
REQ-029 The bench SHALL cover glitch rejection: Din high for 3 cycles, then low. Required response: Dout stays 0, Rise and Fall never assert, and Busy returns to 0.
REQ-030 The bench SHALL cover Enable gating: Enable toggled 1,0,1,0,... with Din held at 1. Required response: Dout rises only after 4 enabled mismatching edges (about 10 edges total); the counter holds on the disabled cycles.
REQ-031 The bench SHALL cover the fall path: from Dout=1, Din 1->0 and held. Required response: Fall pulses for one cycle and Dout=0, 6 edges later.
REQ-032 The bench SHALL cover reset mid-count: Clear=1 while the counter is 2. Required response: the next edge shows counter 0, Busy 0, Dout 0, no pulse; with Din still 1, Rise occurs 6 edges after Clear is released.
REQ-033 Throughout all scenarios, the bench SHALL check continuously that Rise and Fall are never both high and that no pulse lasts longer than one cycle.
